nametable_write_arbiter: RTL

- Shares the single write port of the nametable/attribute RAM between two requesters: the scroll engine (flash-to-nametable refill) and CPU bus writes.
- CPU writes are buffered in a small FIFO so the bus side never waits.
- Scroll writes use a valid/ready handshake.
- A burst-limited arbiter interleaves the two sources, and a hold input freezes all writes.

---
 rtl/nametable_write_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/nametable_write_arbiter.sv
// nametable_write_arbiter: shares the nametable/attribute RAM write port between scroll refill and FIFO-buffered CPU writes
module nametable_write_arbiter #(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_BURST  = 8,
    parameter int ADDR_W     = 9
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               hold,
    input  logic                               sc_valid,
    output logic                               sc_ready,
    input  logic                               sc_attr,
    input  logic [ADDR_W-1:0]                  sc_addr,
    input  logic [31:0]                        sc_data,
    input  logic [3:0]                         sc_be,
    input  logic                               cpu_valid,
    output logic                               cpu_ready,
    input  logic                               cpu_attr,
    input  logic [ADDR_W-1:0]                  cpu_addr,
    input  logic [31:0]                        cpu_data,
    input  logic [3:0]                         cpu_be,
    output logic [3:0]                         ram_name_we,
    output logic [3:0]                         ram_attr_we,
    output logic [ADDR_W-1:0]                  ram_addr,
    output logic [31:0]                        ram_wdata,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    cpu_fifo_level,
    output logic                               ovf_flag,
    input  logic                               ovf_clr,
    output logic                               busy
);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int EW = ADDR_W + 37;

    typedef enum logic [1:0] {IDLE, SCROLL, CPU} state_t;

    state_t              state, owner;
    logic [BW-1:0]       burst_cnt;
    logic [EW-1:0]       fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr, rd_ptr;
    logic                sp, cp, push, pop, grant, last, ram_wr;
    logic                g_attr;
    logic [ADDR_W-1:0]   g_addr;
    logic [31:0]         g_data;
    logic [3:0]          g_be;

    assign cpu_ready = cpu_fifo_level < LW'(FIFO_DEPTH);
    assign push      = cpu_valid & cpu_ready;
    assign sp        = sc_valid;
    assign cp        = cpu_fifo_level != '0;
    assign last      = burst_cnt == BW'(MAX_BURST - 1);
    assign sc_ready  = owner == SCROLL;
    assign pop       = owner == CPU;
    assign grant     = sc_ready | pop;
    assign busy      = cp | sc_valid | ram_wr;
    assign {g_attr, g_addr, g_data, g_be} = pop ? fifo_mem[rd_ptr] : {sc_attr, sc_addr, sc_data, sc_be};

    // Grant owner this cycle: burst-limited alternation, scroll preferred from idle
    always_comb begin
        owner = hold ? IDLE :
                state == SCROLL ? (sp ? ((cp && last) ? CPU : SCROLL) : (cp ? CPU : IDLE)) :
                state == CPU    ? (cp ? ((sp && last) ? SCROLL : CPU) : (sp ? SCROLL : IDLE)) :
                sp ? SCROLL : (cp ? CPU : IDLE);
    end

    // Arbiter state and saturating burst counter, both frozen while hold is high
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            burst_cnt <= '0;
        end else if (!hold) begin
            state     <= owner;
            burst_cnt <= (owner == IDLE || owner != state) ? '0 : last ? burst_cnt : burst_cnt + BW'(1);
        end
    end

    // CPU FIFO storage; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {cpu_attr, cpu_addr, cpu_data, cpu_be};
    end

    // CPU FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            cpu_fifo_level <= '0;
        end else begin
            wr_ptr         <= wr_ptr + PW'(push);
            rd_ptr         <= rd_ptr + PW'(pop);
            cpu_fifo_level <= cpu_fifo_level + LW'(push) - LW'(pop);
        end
    end

    // Sticky overflow: a dropped CPU write beats a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ovf_flag <= 1'b0;
        else     ovf_flag <= (cpu_valid & ~cpu_ready) ? 1'b1 : ovf_clr ? 1'b0 : ovf_flag;
    end

    // RAM write port, one cycle after the grant; address/data hold when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_wr      <= 1'b0;
            ram_name_we <= '0;
            ram_attr_we <= '0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
        end else begin
            ram_wr      <= grant;
            ram_name_we <= (grant && !g_attr) ? g_be : '0;
            ram_attr_we <= (grant && g_attr) ? g_be : '0;
            if (grant) begin
                ram_addr  <= g_addr;
                ram_wdata <= g_data;
            end
        end
    end
endmodule
